// File: rtl/weight_pattern_gen.sv
// ---------------------------------------------------------------------------
// weight_pattern_gen
//
// Streams every WIDTH-bit word that holds exactly k ones, in ascending numeric
// order, one word per accepted transfer. It is the inverse of the ones-counter
// and can drive it directly as an exhaustive pattern source.
//
// Parameters
//   WIDTH     : width of the generated words
//   KW        : width of the weight input (2**KW must exceed WIDTH)
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   reset     : asynchronous, active-low reset
//   i_start   : request a new enumeration (sampled in IDLE only)
//   i_weight  : requested number of ones k (sampled with i_start)
//   i_ready   : downstream accepts o_word this cycle
//   o_valid   : o_word holds a valid pattern
//   o_word    : current pattern, popcount == k
//   o_last    : o_word is the final pattern of the sequence
//   o_busy    : enumeration in progress (state is RUN)
//   o_done    : one-cycle pulse after the last word transfers
//   o_err     : one-cycle pulse when a start is rejected (k > WIDTH)
//   o_chk_err : sticky popcount self-check failure
//
// Handshake: a transfer happens on a rising edge where o_valid and i_ready are
// both 1. While o_valid is 1 and i_ready is 0, o_word and o_last hold steady.
// o_valid never drops without a transfer, except on reset.
//
// Build option
//   WPG_SELF_CHECK_EN : when defined, the popcount of every valid o_word is
//                       compared with the latched weight and any mismatch
//                       sets o_chk_err until reset. When undefined, o_chk_err
//                       is tied to 0. The port list is the same either way.
// ---------------------------------------------------------------------------
module weight_pattern_gen #(
   parameter int WIDTH = 16,
   parameter int KW    = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   input  logic [KW-1:0]    i_weight,
   input  logic             i_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_word,
   output logic             o_last,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err,
   output logic             o_chk_err
);

   localparam int TZW = $clog2(WIDTH);
   // Shift amount must reach tz + 2, which can exceed WIDTH-1.
   localparam int SHW = TZW + 2;
   localparam logic [WIDTH-1:0] ALL_ONES = '1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic [KW-1:0]    weight_q, weight_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   // Priority encoder: index of the lowest set bit. The loop runs high to low
   // so the lowest set bit is the last one written.
   function automatic logic [TZW-1:0] trailing_zeros(input logic [WIDTH-1:0] v);
      logic [TZW-1:0] idx;
      idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (v[i]) idx = TZW'(i);
      end
      return idx;
   endfunction

   // Next-pattern datapath (Gosper's hack without a divider).
   logic [WIDTH-1:0] lowest_bit;
   logic [WIDTH-1:0] ripple;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] next_word;
   logic [WIDTH-1:0] first_word;
   logic [WIDTH-1:0] last_word;
   logic             is_last;
   logic             weight_bad;
   logic             xfer;

   always_comb begin
      lowest_bit = word_q & (~word_q + WIDTH'(1));
      ripple     = word_q + lowest_bit;
      shamt      = SHW'(trailing_zeros(lowest_bit)) + SHW'(2);
      next_word  = ((ripple ^ word_q) >> shamt) | ripple;
   end

   // First word: k ones at the bottom. Last word: k ones at the top.
   // Both shift forms give the right answer for k = 0 and k = WIDTH.
   assign first_word = ~(ALL_ONES << i_weight);
   assign last_word  = ~(ALL_ONES >> weight_q);
   assign is_last    = (word_q == last_word);
   assign weight_bad = (i_weight > KW'(WIDTH));
   assign xfer       = (state_q == RUN) && i_ready;

   // Next-state and datapath update.
   always_comb begin
      state_d  = state_q;
      word_d   = word_q;
      weight_d = weight_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               if (weight_bad) begin
                  err_d = 1'b1;
               end else begin
                  state_d  = RUN;
                  word_d   = first_word;
                  weight_d = i_weight;
               end
            end
         end
         RUN: begin
            // i_start is deliberately ignored here.
            if (xfer) begin
               if (is_last) begin
                  state_d = IDLE;
                  word_d  = '0;
                  done_d  = 1'b1;
               end else begin
                  word_d  = next_word;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         word_q   <= '0;
         weight_q <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         word_q   <= word_d;
         weight_q <= weight_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign o_valid = (state_q == RUN);
   assign o_busy  = (state_q == RUN);
   assign o_word  = word_q;
   // weight_q survives into IDLE, so o_last is gated by the state.
   assign o_last  = (state_q == RUN) && is_last;
   assign o_done  = done_q;
   assign o_err   = err_q;

`ifdef WPG_SELF_CHECK_EN
   function automatic logic [KW-1:0] popcount(input logic [WIDTH-1:0] v);
      logic [KW-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt = cnt + KW'(v[i]);
      end
      return cnt;
   endfunction

   logic chk_err_q;

   // Sticky until reset; a new start does not clear it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         chk_err_q <= 1'b0;
      end else if (o_valid && (popcount(word_q) != weight_q)) begin
         chk_err_q <= 1'b1;
      end
   end

   assign o_chk_err = chk_err_q;
`else
   assign o_chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_weight_pattern_gen.sv
module tb_weight_pattern_gen;

   localparam int WIDTH = 16;
   localparam int KW    = 5;

   // ---------------- clock / reset ----------------
   logic             clk = 1'b0;
   logic             reset;
   logic             i_start;
   logic [KW-1:0]    i_weight;
   logic             i_ready;
   logic             o_valid;
   logic [WIDTH-1:0] o_word;
   logic             o_last;
   logic             o_busy;
   logic             o_done;
   logic             o_err;
   logic             o_chk_err;

   always #5 clk = ~clk;

   weight_pattern_gen #(.WIDTH(WIDTH), .KW(KW)) dut (
      .clk       (clk),
      .reset     (reset),
      .i_start   (i_start),
      .i_weight  (i_weight),
      .i_ready   (i_ready),
      .o_valid   (o_valid),
      .o_word    (o_word),
      .o_last    (o_last),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .o_err     (o_err),
      .o_chk_err (o_chk_err)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int passes = 0;
   logic [WIDTH-1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic int popcnt(input logic [WIDTH-1:0] w);
      int c;
      c = 0;
      for (int i = 0; i < WIDTH; i++) c += int'(w[i]);
      return c;
   endfunction

   // ---------------- vector table ----------------
   typedef struct {
      string            name;
      logic [KW-1:0]    weight;
      logic             expect_err;
      int               count;
      logic [WIDTH-1:0] first_word;
      logic [WIDTH-1:0] second_word;
      logic [WIDTH-1:0] third_word;
      logic [WIDTH-1:0] last_word;
   } vec_t;

   vec_t vecs[6];

   // Start an enumeration with ready held high and follow it to o_done.
   task automatic run_vec(input vec_t v);
      int n, bad_pop, bad_order, bad_last;
      logic [WIDTH-1:0] prev, w2, w3;
      bit saw_last;
      @(negedge clk);
      i_start  = 1'b1;
      i_weight = v.weight;
      i_ready  = 1'b1;
      @(negedge clk);
      i_start  = 1'b0;
      if (v.expect_err) begin
         check({v.name, " err pulse"}, 32'(o_err), 32'd1);
         check({v.name, " err valid"}, 32'(o_valid), 32'd0);
         check({v.name, " err busy"}, 32'(o_busy), 32'd0);
         @(negedge clk);
         check({v.name, " err width"}, 32'(o_err), 32'd0);
         check({v.name, " err valid2"}, 32'(o_valid), 32'd0);
         return;
      end
      check({v.name, " valid latency"}, 32'(o_valid), 32'd1);
      check({v.name, " busy"}, 32'(o_busy), 32'd1);
      check({v.name, " first word"}, 32'(o_word), 32'(v.first_word));
      n = 0; bad_pop = 0; bad_order = 0; bad_last = 0;
      prev = '0; w2 = '0; w3 = '0; saw_last = 1'b0;
      for (int cyc = 0; cyc < v.count + 8 && !saw_last; cyc++) begin
         if (o_valid) begin
            if (popcnt(o_word) != int'(v.weight)) bad_pop++;
            if (n > 0 && o_word <= prev) bad_order++;
            if (o_last != (o_word == v.last_word)) bad_last++;
            if (n == 1) w2 = o_word;
            if (n == 2) w3 = o_word;
            prev = o_word;
            n++;
            if (o_last) saw_last = 1'b1;
         end
         @(negedge clk);
      end
      check({v.name, " saw last"}, 32'(saw_last), 32'd1);
      check({v.name, " word count"}, 32'(n), 32'(v.count));
      check({v.name, " last word"}, 32'(prev), 32'(v.last_word));
      check({v.name, " popcount errors"}, 32'(bad_pop), 32'd0);
      check({v.name, " order errors"}, 32'(bad_order), 32'd0);
      check({v.name, " o_last errors"}, 32'(bad_last), 32'd0);
      if (v.count >= 3) begin
         check({v.name, " second word"}, 32'(w2), 32'(v.second_word));
         check({v.name, " third word"}, 32'(w3), 32'(v.third_word));
      end
      check({v.name, " done pulse"}, 32'(o_done), 32'd1);
      check({v.name, " idle valid"}, 32'(o_valid), 32'd0);
      check({v.name, " idle busy"}, 32'(o_busy), 32'd0);
      check({v.name, " idle word"}, 32'(o_word), 32'd0);
      @(negedge clk);
      check({v.name, " done width"}, 32'(o_done), 32'd0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int n, bad_pop;
      logic [WIDTH-1:0] prev;
      bit saw_last;

      vecs[0] = '{"k0",  5'd0,  1'b0, 1,     16'h0000, 16'h0000, 16'h0000, 16'h0000};
      vecs[1] = '{"k1",  5'd1,  1'b0, 16,    16'h0001, 16'h0002, 16'h0004, 16'h8000};
      vecs[2] = '{"k2",  5'd2,  1'b0, 120,   16'h0003, 16'h0005, 16'h0006, 16'hC000};
      vecs[3] = '{"k8",  5'd8,  1'b0, 12870, 16'h00FF, 16'h017F, 16'h01BF, 16'hFF00};
      vecs[4] = '{"k16", 5'd16, 1'b0, 1,     16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF};
      vecs[5] = '{"k17", 5'd17, 1'b1, 0,     16'h0000, 16'h0000, 16'h0000, 16'h0000};

      reset    = 1'b0;
      i_start  = 1'b0;
      i_weight = '0;
      i_ready  = 1'b0;
      repeat (2) @(negedge clk);
      check("reset valid", 32'(o_valid), 32'd0);
      check("reset word", 32'(o_word), 32'd0);
      check("reset last", 32'(o_last), 32'd0);
      check("reset busy", 32'(o_busy), 32'd0);
      check("reset done", 32'(o_done), 32'd0);
      check("reset err", 32'(o_err), 32'd0);
      check("reset chk_err", 32'(o_chk_err), 32'd0);
      reset = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Backpressure on k=3, with a stray start (k=5) while running.
      exp_q = '{16'h0007, 16'h000B, 16'h000D, 16'h000E, 16'h0013};
      @(negedge clk);
      i_start  = 1'b1;
      i_weight = 5'd3;
      i_ready  = 1'b1;
      @(negedge clk);
      i_start  = 1'b0;
      check("bp word1", 32'(o_word), 32'(exp_q.pop_front()));
      @(negedge clk);
      check("bp word2", 32'(o_word), 32'(exp_q.pop_front()));
      i_ready  = 1'b0;
      i_start  = 1'b1;
      i_weight = 5'd5;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         i_start = 1'b0;
         check($sformatf("bp hold word %0d", i), 32'(o_word), 32'h000B);
         check($sformatf("bp hold valid %0d", i), 32'(o_valid), 32'd1);
         check($sformatf("bp hold last %0d", i), 32'(o_last), 32'd0);
      end
      i_ready = 1'b1;
      @(negedge clk);
      check("bp word3", 32'(o_word), 32'(exp_q.pop_front()));
      @(negedge clk);
      check("bp word4", 32'(o_word), 32'(exp_q.pop_front()));
      @(negedge clk);
      check("bp word5", 32'(o_word), 32'(exp_q.pop_front()));
      n = 4; bad_pop = 0; prev = '0; saw_last = 1'b0;
      for (int cyc = 0; cyc < 600 && !saw_last; cyc++) begin
         if (o_valid) begin
            if (popcnt(o_word) != 3) bad_pop++;
            prev = o_word;
            n++;
            if (o_last) saw_last = 1'b1;
         end
         @(negedge clk);
      end
      check("bp total words", 32'(n), 32'd560);
      check("bp last word", 32'(prev), 32'hE000);
      check("bp popcount errors", 32'(bad_pop), 32'd0);
      check("bp done", 32'(o_done), 32'd1);

      // Reset in the middle of a k=4 run.
      @(negedge clk);
      i_start  = 1'b1;
      i_weight = 5'd4;
      @(negedge clk);
      i_start  = 1'b0;
      repeat (10) @(negedge clk);
      check("mid word11", 32'(o_word), 32'h0035);
      check("mid chk_err", 32'(o_chk_err), 32'd0);
      reset = 1'b0;
      #1;
      check("async valid", 32'(o_valid), 32'd0);
      check("async word", 32'(o_word), 32'd0);
      check("async busy", 32'(o_busy), 32'd0);
      check("async last", 32'(o_last), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("post reset idle", 32'(o_valid), 32'd0);
      i_start  = 1'b1;
      i_weight = 5'd4;
      @(negedge clk);
      i_start  = 1'b0;
      check("restart first", 32'(o_word), 32'h000F);
      check("restart valid", 32'(o_valid), 32'd1);
      @(negedge clk);
      check("restart second", 32'(o_word), 32'h0017);
      check("final chk_err", 32'(o_chk_err), 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
